// File: rtl/pipe_reg_chain_pkg.sv
// -----------------------------------------------------------------------------
// pipe_reg_chain_pkg
//   Shared types for the elastic register pipeline.
//   stage_op_e names what a single stage does on the next clock edge. The
//   stage register decodes its control inputs into one of these.
// -----------------------------------------------------------------------------
package pipe_reg_chain_pkg;

    typedef enum logic [1:0] {
        STG_HOLD        = 2'd0,  // downstream stalled, keep data and valid
        STG_LOAD_BEAT   = 2'd1,  // capture upstream data, become valid
        STG_LOAD_BUBBLE = 2'd2,  // upstream empty: clear valid, keep old data
        STG_FLUSH       = 2'd3   // invalidate, keep old data
    } stage_op_e;

endpackage : pipe_reg_chain_pkg

// File: rtl/pipe_reg_chain_stage.sv
// -----------------------------------------------------------------------------
// pipe_reg_stage
//   One stage of the elastic pipeline: a WIDTH-bit data register plus a valid
//   bit. The data register is only written when a valid beat arrives, so a
//   bubble or a flush clears the valid bit and leaves the payload untouched.
// Ports
//   clk       in   clock, posedge
//   reset     in   synchronous active-high reset (valid=0, data=RESET_VAL)
//   flush     in   clear valid at this edge, data unchanged
//   load      in   stage may take its upstream slot this cycle (ready chain)
//   in_valid  in   upstream valid
//   in_data   in   upstream payload
//   valid     out  registered valid bit
//   data      out  registered payload
// -----------------------------------------------------------------------------
module pipe_reg_stage
    import pipe_reg_chain_pkg::*;
#(
    parameter int                WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             load,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;
    stage_op_e        op;

    always_comb begin
        op = STG_HOLD;
        if (flush) begin
            op = STG_FLUSH;
        end else if (load) begin
            op = in_valid ? STG_LOAD_BEAT : STG_LOAD_BUBBLE;
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        unique case (op)
            STG_HOLD: begin
                valid_d = valid_q;
            end
            STG_LOAD_BEAT: begin
                valid_d = 1'b1;
                data_d  = in_data;
            end
            STG_LOAD_BUBBLE,
            STG_FLUSH: begin
                valid_d = 1'b0;
            end
            default: begin
                valid_d = valid_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule : pipe_reg_stage

// File: rtl/pipe_reg_chain.sv
// -----------------------------------------------------------------------------
// pipe_reg_chain
//   Elastic register pipeline: WIDTH-bit payload through STAGES registered
//   stages with valid/ready handshake, bubble collapsing and flush.
//   Latency STAGES cycles, throughput one beat per cycle with out_ready=1.
// Ports
//   clk        in   clock, posedge
//   reset      in   synchronous active-high reset, overrides everything
//   flush      in   invalidate all stages at this edge; blocks input
//   in_valid   in   producer offers in_data
//   in_ready   out  stage 0 can accept this cycle
//   in_data    in   payload in
//   out_valid  out  last stage holds a valid beat
//   out_ready  in   consumer accepts out_data
//   out_data   out  payload out (last stage data register)
//   occupancy  out  number of valid stages, 0..STAGES
// Timing note: out_ready -> in_ready is combinational through the whole ready
// chain (STAGES deep). in_valid and in_data only reach registers.
// -----------------------------------------------------------------------------
module pipe_reg_chain
    import pipe_reg_chain_pkg::*;
#(
    parameter int                WIDTH     = 8,
    parameter int                STAGES    = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(STAGES+1)-1:0]  occupancy
);

    localparam int OCC_W = $clog2(STAGES + 1);

    generate
        if (STAGES < 1) begin : g_bad_stages
            $error("pipe_reg_chain: STAGES must be >= 1");
        end
    endgenerate

    logic [STAGES-1:0] v_vec;
    logic [WIDTH-1:0]  d_arr [STAGES];
    logic [STAGES:0]   rdy;
    logic [OCC_W-1:0]  occ_sum;

    // A stage is ready if it is empty or the stage after it is ready, so
    // empty slots fill even while the output is stalled (bubble collapse).
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            rdy[i] = !v_vec[i] | rdy[i+1];
        end
    end

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            logic             up_valid;
            logic [WIDTH-1:0] up_data;

            if (gi == 0) begin : g_head
                assign up_valid = in_valid;
                assign up_data  = in_data;
            end else begin : g_body
                assign up_valid = v_vec[gi-1];
                assign up_data  = d_arr[gi-1];
            end

            pipe_reg_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clk      (clk),
                .reset    (reset),
                .flush    (flush),
                .load     (rdy[gi]),
                .in_valid (up_valid),
                .in_data  (up_data),
                .valid    (v_vec[gi]),
                .data     (d_arr[gi])
            );
        end
    endgenerate

    always_comb begin
        occ_sum = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ_sum = occ_sum + OCC_W'(v_vec[i]);
        end
    end

    // Flush blocks the input; stage 0 also ignores in_valid under flush.
    assign in_ready  = rdy[0] & !flush;
    assign out_valid = v_vec[STAGES-1];
    assign out_data  = d_arr[STAGES-1];
    assign occupancy = occ_sum;

endmodule : pipe_reg_chain
